reduce_seq: RTL and testbench



---
 rtl/reduce_seq.sv | 125 ++++++++++++
 tb/tb_reduce_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_seq.sv
// Multi-cycle reduction sequencer: walks a WIDTH-bit operand LSB-first through one
// CHUNK-wide AND/OR/XOR reducer, stopping early once the result is decided.
module reduce_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic [2:0]                          in_op,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_y,
  output logic                                out_err,
  output logic [$clog2(WIDTH/CHUNK+1)-1:0]    out_cycles,
  output logic                                busy,
  output logic [1:0]                          fsm_state
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK + 1);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 1) begin : g_bad_geometry
    $error("reduce_seq: WIDTH must be a positive multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state, state_next;
  logic [WIDTH-1:0]  data_q;
  logic [2:0]        op_q;
  logic [CW-1:0]     cnt;
  logic              acc;
  logic              y_q;
  logic              err_q;
  logic [CW-1:0]     cycles_q;

  logic [CHUNK-1:0]  chunk;
  logic              r;
  logic              acc_next;
  logic              finish;
  logic              reserved_in;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and the DONE result stays stable until taken.

  // data_q is shifted right each RUN cycle, so the current chunk is always the low slice.
  assign chunk       = data_q[CHUNK-1:0];
  assign reserved_in = (in_op[1:0] == 2'b11);

  always_comb begin
    r          = 1'b0;
    acc_next   = acc;
    finish     = 1'b0;
    state_next = state;
    case (op_q[1:0])
      2'b00:   begin r = &chunk; acc_next = acc & r; end
      2'b01:   begin r = |chunk; acc_next = acc | r; end
      default: begin r = ^chunk; acc_next = acc ^ r; end
    endcase
    // AND decided by any zero chunk, OR by any non-zero chunk; XOR must see all.
    if (cnt == LAST || (op_q[1:0] == 2'b00 && !r) || (op_q[1:0] == 2'b01 && r)) begin
      finish = 1'b1;
    end
    case (state)
      IDLE:    if (in_valid) state_next = reserved_in ? DONE : RUN;
      RUN:     if (finish) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      data_q   <= '0;
      op_q     <= '0;
      cnt      <= '0;
      acc      <= 1'b0;
      y_q      <= 1'b0;
      err_q    <= 1'b0;
      cycles_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            data_q <= in_data;
            op_q   <= in_op;
            cnt    <= '0;
            acc    <= (in_op[1:0] == 2'b00);
            if (reserved_in) begin
              y_q      <= 1'b0;
              err_q    <= 1'b1;
              cycles_q <= '0;
            end
          end
        end
        RUN: begin
          acc    <= acc_next;
          cnt    <= cnt + CW'(1);
          data_q <= data_q >> CHUNK;
          if (finish) begin
            y_q      <= acc_next ^ op_q[2];
            err_q    <= 1'b0;
            cycles_q <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign out_valid  = (state == DONE);
  assign out_y      = y_q;
  assign out_err    = err_q;
  assign out_cycles = cycles_q;
  assign fsm_state  = state;

endmodule

// File: tb/tb_reduce_seq.sv
// Self-checking bench for reduce_seq: directed ops, backpressure, mid-op reset,
// reserved op; a spec-level model feeds an expected queue checked every cycle.
module tb_reduce_seq;

  localparam int WIDTH  = 32;
  localparam int CHUNK  = 8;
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = 3;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic             out_y;
  logic             out_err;
  logic [CW-1:0]    out_cycles;
  logic             busy;
  logic [1:0]       fsm_state;

  reduce_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_err(out_err),
    .out_cycles(out_cycles), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // entry: [31:16] accept cycle, [12:5] edges from accept to out_valid, [4:2] cycles, [1] err, [0] y
  logic [31:0] exp_q[$];
  logic [31:0] cur = '0;
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result decided by the whole operand; chunk count is where the outcome was first settled.
  function automatic logic [15:0] model(input logic [2:0] op, input logic [WIDTH-1:0] d);
    logic y, err, found;
    int ncyc;
    logic [CHUNK-1:0] ch;
    y = 1'b0; err = 1'b0; found = 1'b0; ncyc = NCHUNK;
    case (op[1:0])
      2'b00: begin
        y = &d;
        for (int k = 0; k < NCHUNK; k++) begin
          ch = CHUNK'(d >> (k * CHUNK));
          if (!found && ch != {CHUNK{1'b1}}) begin ncyc = k + 1; found = 1'b1; end
        end
      end
      2'b01: begin
        y = |d;
        for (int k = 0; k < NCHUNK; k++) begin
          ch = CHUNK'(d >> (k * CHUNK));
          if (!found && ch != '0) begin ncyc = k + 1; found = 1'b1; end
        end
      end
      2'b10: y = ^d;
      default: begin err = 1'b1; ncyc = 0; end
    endcase
    if (!err) y = y ^ op[2];
    return {3'b000, 8'(err ? 0 : ncyc), 3'(ncyc), err, y};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] d, output int acc_cyc);
    int n;
    n = 0;
    in_op = op; in_data = d; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    acc_cyc = cyc + 1;
    exp_q.push_back({16'(acc_cyc), model(op, d)});
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    in_op    = 3'($urandom_range(0, 7));
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_out_y"}, 32'(out_y), 0);
    check({tag, "_out_err"}, 32'(out_err), 0);
    check({tag, "_out_cycles"}, 32'(out_cycles), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
  endtask

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      check("ready_vs_busy", 32'(in_ready), 32'(!busy));
      if (prev_hs) begin
        check("after_hs_valid", 32'(out_valid), 0);
        check("after_hs_ready", 32'(in_ready), 1);
      end
      if (out_valid) begin
        check("ready_in_done", 32'(in_ready), 0);
        if (!prev_valid) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL spurious_out_valid: got out_valid=1 expected no pending result");
          end else begin
            cur = exp_q.pop_front();
            check("latency", 32'(cyc) - {16'b0, cur[31:16]}, {24'b0, cur[12:5]});
          end
        end
        check("out_y", 32'(out_y), {31'b0, cur[0]});
        check("out_err", 32'(out_err), {31'b0, cur[1]});
        check("out_cycles", 32'(out_cycles), {29'b0, cur[4:2]});
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int a, a2, h, n;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b1;
    #1;
    check_reset_outputs("por");

    // hand-computed pins on the model
    check("pin_and_ones",   32'(model(3'b000, 32'hFFFF_FFFF)), {16'b0, 3'b0, 8'd4, 3'd4, 1'b0, 1'b1});
    check("pin_and_early",  32'(model(3'b000, 32'hFFFF_00FF)), {16'b0, 3'b0, 8'd2, 3'd2, 1'b0, 1'b0});
    check("pin_nand_early", 32'(model(3'b100, 32'hFFFF_00FF)), {16'b0, 3'b0, 8'd2, 3'd2, 1'b0, 1'b1});
    check("pin_xor7",       32'(model(3'b010, 32'h0000_0007)), {16'b0, 3'b0, 8'd4, 3'd4, 1'b0, 1'b1});
    check("pin_xnor7",      32'(model(3'b110, 32'h0000_0007)), {16'b0, 3'b0, 8'd4, 3'd4, 1'b0, 1'b0});
    check("pin_or_10",      32'(model(3'b001, 32'h0000_0010)), {16'b0, 3'b0, 8'd1, 3'd1, 1'b0, 1'b1});
    check("pin_nor_0",      32'(model(3'b101, 32'h0000_0000)), {16'b0, 3'b0, 8'd4, 3'd4, 1'b0, 1'b1});
    check("pin_reserved",   32'(model(3'b111, 32'h1234_5678)), {16'b0, 3'b0, 8'd0, 3'd0, 1'b1, 1'b0});

    #20; @(posedge clk); #1;
    reset_n = 1'b1;
    idle_cycles(2);

    // directed vectors, consumer always ready
    send(3'b000, 32'hFFFF_FFFF, a);
    send(3'b000, 32'hFFFF_00FF, a);
    send(3'b100, 32'hFFFF_00FF, a);
    send(3'b010, 32'h0000_0007, a);
    send(3'b110, 32'h0000_0007, a);
    send(3'b001, 32'h0000_0010, a);
    send(3'b101, 32'h0000_0000, a);
    send(3'b001, 32'h0100_0000, a);
    send(3'b000, 32'h00FF_FFFF, a);
    send(3'b010, 32'hFFFF_FFFF, a);
    send(3'b100, 32'h0000_0000, a);
    idle_cycles(6);

    // backpressure: result held for 10 cycles while in_valid pulses are ignored
    out_ready = 1'b0;
    send(3'b000, 32'hFFFF_FFFF, a);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_out_valid_seen", 32'(out_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = i[0];
      in_data  = $urandom;
      in_op    = 3'b001;
      check("bp_in_ready_low", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    h = cyc;
    out_ready = 1'b1;
    send(3'b010, 32'h0000_0007, a2);
    check("bp_next_accept_cycle", 32'(a2), 32'(h + 2));
    idle_cycles(6);

    // reset during the second RUN cycle aborts the op
    send(3'b010, 32'h0000_FFFF, a);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midrun");
    exp_q.delete();
    idle_cycles(2);
    reset_n = 1'b1;
    idle_cycles(1);
    send(3'b010, 32'h0000_0001, a);
    idle_cycles(6);

    // reserved op then a valid op clearing out_err
    send(3'b111, 32'hDEAD_BEEF, a);
    send(3'b001, 32'h0000_0100, a);
    idle_cycles(2);

    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin @(posedge clk); #1; n++; end
    check("drain_queue_empty", 32'(exp_q.size()), 0);
    idle_cycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
